// File: rtl/axis_width_pkg.sv
// Shared types and helpers for the AXI-Stream width converters (destruct/combin).
// Holds the two-state FSM encoding and the last-populated-lane search.
package axis_width_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } width_state_e;

  localparam int MAX_KEEP_W = 64;

  // Keep slices are only meaningful when a lane is a power-of-two number of bytes.
  function automatic bit keep_is_bytewise(input int dsize);
    int nbytes;
    nbytes = dsize / 8;
    return (dsize > 0) && (dsize % 8 == 0) && ((nbytes & (nbytes - 1)) == 0);
  endfunction

  // Highest lane (MS-lane-first numbering) with any keep bit set; 0 when keep is empty.
  function automatic int last_nonzero_lane(input logic [MAX_KEEP_W-1:0] keep,
                                           input int nsize, input int ksize);
    int lst;
    logic [MAX_KEEP_W-1:0] mask;
    logic [MAX_KEEP_W-1:0] slice;
    lst  = 0;
    mask = ~({MAX_KEEP_W{1'b1}} << ksize);
    for (int i = 0; i < MAX_KEEP_W; i++) begin
      if (i < nsize) begin
        slice = (keep >> (ksize * (nsize - 1 - i))) & mask;
        if (slice != '0) lst = i;
      end
    end
    return lst;
  endfunction

endpackage

// File: rtl/axi_stream_inf.sv
// AXI-Stream bundle shared by the wide and slim sides of the width converters.
interface axi_stream_inf #(
  parameter int DSIZE = 8,
  parameter int KSIZE = (DSIZE + 7) / 8,
  parameter int USIZE = 1
);
  logic [DSIZE-1:0] tdata;
  logic [KSIZE-1:0] tkeep;
  logic             tvalid;
  logic             tready;
  logic             tlast;
  logic [USIZE-1:0] tuser;

  modport master (output tdata, output tkeep, output tvalid, output tlast, output tuser,
                  input  tready);
  modport slaver (input  tdata, input  tkeep, input  tvalid, input  tlast, input  tuser,
                  output tready);
endinterface

// File: rtl/axis_width_destruct_a2.sv
// Wide-to-slim AXI-Stream splitter: one held wide beat is emitted as NSIZE slim lanes,
// most-significant lane first, trimming trailing empty lanes on the packet's last beat.
module axis_width_destruct_a2
  import axis_width_pkg::*;
(
  input  logic          clock,
  input  logic          rst,
  axi_stream_inf.slaver wide_axis,
  axi_stream_inf.master slim_axis
);

  localparam int  WD      = $bits(wide_axis.tdata);
  localparam int  SD      = $bits(slim_axis.tdata);
  localparam int  WK      = $bits(wide_axis.tkeep);
  localparam int  KSIZE   = $bits(slim_axis.tkeep);
  localparam int  UW      = $bits(wide_axis.tuser);
  localparam int  NSIZE   = WD / SD;
  localparam int  PW      = (NSIZE > 1) ? $clog2(NSIZE) : 1;
  localparam bit  KEEP_OK = keep_is_bytewise(SD);

  if ((WD % SD) != 0 || NSIZE < 2) begin : g_bad_ratio
    $error("axis_width_destruct_a2: wide width %0d is not a >=2 multiple of slim width %0d", WD, SD);
  end

  width_state_e   state_q, state_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [PW-1:0]  fin_q, fin_d;
  logic [WD-1:0]  data_q, data_d;
  logic [WK-1:0]  keep_q, keep_d;
  logic           tlast_q, tlast_d;
  logic [UW-1:0]  user_q, user_d;
  logic           rdy_en_q;
  logic           fin_lane;
  logic           wide_hs;
  logic           slim_hs;
  int             ptr_i;

  assign ptr_i    = int'(ptr_q);
  assign fin_lane = (ptr_q == fin_q);
  assign wide_hs  = wide_axis.tvalid && wide_axis.tready;
  assign slim_hs  = slim_axis.tvalid && slim_axis.tready;

  // Accept a new beat while empty, or in the same cycle the final lane leaves.
  assign wide_axis.tready = rdy_en_q &&
                            ((state_q == ST_IDLE) || (fin_lane && slim_axis.tready));

  assign slim_axis.tvalid = (state_q == ST_EMIT);
  assign slim_axis.tdata  = data_q[SD*(NSIZE-ptr_i)-1 -: SD];
  assign slim_axis.tlast  = tlast_q && fin_lane;
  assign slim_axis.tuser  = user_q;

  if (KEEP_OK) begin : g_keep_slice
    assign slim_axis.tkeep = keep_q[KSIZE*(NSIZE-ptr_i)-1 -: KSIZE];
  end else begin : g_keep_ones
    assign slim_axis.tkeep = '1;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    fin_d   = fin_q;
    data_d  = data_q;
    keep_d  = keep_q;
    tlast_d = tlast_q;
    user_d  = user_q;

    if (slim_hs) begin
      if (fin_lane) begin
        ptr_d   = '0;
        state_d = ST_IDLE;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end

    // Capture wins over the final-lane drain so back-to-back beats have no bubble.
    if (wide_hs) begin
      state_d = ST_EMIT;
      ptr_d   = '0;
      data_d  = wide_axis.tdata;
      keep_d  = wide_axis.tkeep;
      tlast_d = wide_axis.tlast;
      user_d  = wide_axis.tuser;
      if (KEEP_OK && wide_axis.tlast)
        fin_d = PW'(last_nonzero_lane(MAX_KEEP_W'(wide_axis.tkeep), NSIZE, KSIZE));
      else
        fin_d = PW'(NSIZE - 1);
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      fin_q    <= '0;
      data_q   <= '0;
      keep_q   <= '0;
      tlast_q  <= 1'b0;
      user_q   <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      fin_q    <= fin_d;
      data_q   <= data_d;
      keep_q   <= keep_d;
      tlast_q  <= tlast_d;
      user_q   <= user_d;
      rdy_en_q <= 1'b1;
    end
  end

endmodule

// File: doc/axis_width_destruct_a2.md
AXIS_WIDTH_DESTRUCT_A2 -- requirements
Module: axis_width_destruct_A2

Interface
REQ-001 SHALL take no explicit parameters; widths derive from the interfaces.
REQ-002 SHALL define NSIZE as wide_axis.DSIZE / slim_axis.DSIZE.
REQ-003 SHALL define KSIZE as slim_axis.KSIZE, the keep bits per slim lane.
REQ-004 SHALL assert at elaboration that wide_axis.DSIZE % slim_axis.DSIZE == 0 and NSIZE >= 2, else $error.
REQ-005 Port clock  input  1  rising-edge clock for all state.
REQ-006 Port rst  input  1  reset, asynchronous, active-high.
REQ-007 Port wide_axis  axi_stream_inf.slaver  wide_axis.DSIZE  upstream wide stream (tdata/tkeep/tvalid/tready/tlast/tuser).
REQ-008 Port slim_axis  axi_stream_inf.master  slim_axis.DSIZE  downstream slim stream; feeds the axis_width_combin stage.
REQ-009 SHALL ignore the interfaces' aclk/aresetn; clock and rst are the only timing inputs.

Function
REQ-010 SHALL split each accepted wide beat into slim beats, most-significant lane first (lane i = tdata[DSIZE*(NSIZE-i)-1 -: DSIZE]), matching the combiner's packing order.
REQ-011 SHALL capture a wide beat into a holding register on wide tvalid&&tready; slim tvalid SHALL rise the cycle after capture (latency 1).
REQ-012 SHALL run a two-state FSM: IDLE (holding empty) and EMIT (holding full).
REQ-013 IDLE->EMIT on wide handshake; EMIT->IDLE on handshake of the final lane with no simultaneous wide handshake; EMIT->EMIT on final-lane handshake with a simultaneous wide handshake.
REQ-014 wide tready SHALL be 1 in IDLE, and in EMIT only when the final lane is valid and slim tready is 1 (zero-bubble back-to-back, one slim beat per cycle sustained).
REQ-015 SHALL keep a lane pointer 0..NSIZE-1, cleared on capture and incremented on each slim handshake except the final lane.
REQ-016 For non-last wide beats the final lane SHALL be NSIZE-1.
REQ-017 For a wide beat with tlast=1, the final lane SHALL be the highest-index lane with a nonzero keep slice, computed at capture.
REQ-018 If a tlast beat has all-zero tkeep, SHALL emit lane 0 only, with keep 0 and tlast 1.
REQ-019 slim tkeep SHALL be the lane's KSIZE keep slice.
REQ-020 If slim_axis.DSIZE is not a power-of-two multiple of 8, SHALL drive all-ones keep and emit all NSIZE lanes on every beat.
REQ-021 slim tlast SHALL be 1 only on the final lane of a wide beat whose tlast was 1.
REQ-022 slim tuser SHALL repeat the captured wide tuser on every lane of that beat.
REQ-023 slim tdata/tkeep/tlast/tuser SHALL hold stable while slim tvalid=1 and tready=0.

Reset
REQ-024 On rst assertion, asynchronously: FSM=IDLE, pointer=0, holding data/keep=0.
REQ-025 On rst assertion, asynchronously: slim tvalid/tlast/tuser=0, slim tdata/tkeep=0, wide tready=0.
REQ-026 A beat partially emitted when rst asserts SHALL be discarded, not resumed.
REQ-027 wide tready SHALL become 1 on the first clock edge after rst deasserts.

Structure
REQ-028 SHALL place the FSM state enum and the last-nonzero-lane function in shared package axis_width_pkg, reusable by the combiner.
REQ-029 SHALL be a single module with no sub-module; the lane select is a pointer-indexed part-select.

Verification (wide 32b, slim 8b, NSIZE=4)
REQ-030 Wide 0xAABBCCDD, keep 0xF, last 0, slim tready=1 -> slim AA,BB,CC,DD in 4 consecutive cycles, tlast 0.
REQ-031 Wide 0x11223344 keep 0xF last 0, then 0x55660000 keep 0xC last 1 -> slim 11,22,33,44,55,66 with no bubble; tlast only on 66.
REQ-032 Slim tready toggled 1,0,1,0 -> every lane emitted exactly once, stable while stalled; wide tready low until the final lane handshakes.
REQ-033 tlast beat with keep 0x0 -> exactly one slim beat, data 0x00 (lane 0), keep 0, tlast 1.
REQ-034 rst pulsed after 2 of 4 lanes -> slim tvalid drops immediately; next wide beat 0xDEADBEEF emits DE,AD,BE,EF from lane 0.
REQ-035 Loopback into axis_width_combin (slim to wide), random packets 1..17 slim words, random backpressure -> output equals input packets, including tlast and keep.
